reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-port register file for the processor datapath: the next generation of the core's 16×32 register file. Read and write port counts, data width and depth are configurable. It adds registered write-first reads, deterministic write-port priority, a dedicated PC register slot and a CPSR register. A per-register busy scoreboard lets issue logic see registers whose producing write is still outstanding.

## Interface
- N, 32: data width in bits.
- DEPTH, 16: number of general registers; power of two, ≥ 2.
- AW, 4: address width; equals log2(DEPTH).
- NRD, 4: number of read ports, ≥ 1.
- NWR, 3: number of general write ports, ≥ 1.
- PC_IDX, 15: register index aliased as the PC.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*N  registered read data; port i occupies [i*N +: N].
- rd_busy  out  NRD  registered busy flag of each read port's register.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses, packed like rd_addr.
- wr_data  in  NWR*N  write data, packed like rd_data.
- rsv_en  in  1  reserve request: mark a register busy.
- rsv_addr  in  AW  register to reserve.
- pc_write  in  1  PC update enable.
- pc_update  in  N  new PC value.
- pc  out  N  current content of R[PC_IDX]; combinational from the array.
- cspr_write  in  1  CPSR update enable.
- cspr_update  in  N  new CPSR value.
- cspr  out  N  CPSR register.
- wr_conflict  out  1  one-cycle pulse: two or more enabled write ports targeted the same address in the previous cycle.

## Operation
- Reset while rst=1, asynchronous: all R[k]=0, busy[k]=0, cspr=0, rd_data=0, rd_busy=0, wr_conflict=0, therefore pc=0. This applies at any time, including mid-write. No write in the reset cycle takes effect.
- Write resolution on each edge, per register k:
  - pc_write=1 and k=PC_IDX: R[k] takes pc_update. This overrides every general port.
  - Otherwise, among enabled ports with wr_addr=k, the highest port index wins.
  - If no port targets k, R[k] holds.
- cspr: loads cspr_update when cspr_write=1, otherwise holds.
- Scoreboard, per register k, in priority order:
  - rsv_en=1 and rsv_addr=k: busy[k] is set. The reservation wins over a same-cycle write, because a new producer was issued.
  - Else any general write or pc_write hits k: busy[k] is cleared.
  - Else busy[k] holds.
- Reads, write-first: on each edge, rd_data[i] loads the post-resolution value of R[rd_addr[i]]. This is the value the array will hold after this edge, so same-cycle writes are forwarded. rd_busy[i] loads the post-update busy[rd_addr[i]].
- wr_conflict: registered at each edge. It is 1 iff at least two enabled general ports share an address in that cycle. pc_write does not count.
- Reserving and reading the same register in one cycle returns rd_busy=1.
- Read ports are independent; identical addresses on several ports are legal.

## Timing
- Read latency: one cycle. Address at edge t gives data valid after edge t, stable until edge t+1.
- Write latency: zero to read ports, because of the bypass. The array and pc update at edge t.
- cspr and busy change at the edge. wr_conflict asserts for exactly the one cycle after the offending edge.
- No handshakes; every request is accepted every cycle.
- rst deassertion must meet recovery to clk; the first state update occurs on the first rising edge with rst=0.

## Test plan
- Reset and basic access: assert rst mid-cycle, then release. Write 0xDEADBEEF to R3 via port 0, then read R3 on port 2 the next cycle. Required: all outputs 0 during rst, rd_data[2]=0xDEADBEEF one cycle after the read address is applied.
- Bypass and priority: in one cycle, port0 writes 0x11 and port2 writes 0x22 to R5, while read port 0 addresses R5. Required: rd_data[0]=0x22 after the edge, R5=0x22, wr_conflict=1 for one cycle.
- PC override: pc_write=1 with pc_update=0x100 while port1 writes 0x200 to R15. Required: pc=0x100, and a read of R15 returns 0x100.
- Scoreboard:
  - Reserve R7, then read R7. Required: rd_busy=1.
  - Write R7 while reserving R7 in the same cycle. Required: stays busy.
  - Write R7 alone. Required: rd_busy=0 on the next read.
- CPSR and holds: cspr_write=1 with 0xF0000000, then cspr_write=0 for 3 cycles. Required: cspr=0xF0000000 throughout.
- Parameter sweep: N=16, DEPTH=8, NRD=2, NWR=2, PC_IDX=7. Write R0 through R7 with index×3, then read back on both ports. Required: every value matches and pc=21.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with write-first
// registered reads, highest-index write priority, a PC alias slot, a CPSR
// register and a per-register busy scoreboard for issue logic.
module reg_file_mp #(
  parameter int N      = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int NRD    = 4,
  parameter int NWR    = 3,
  parameter int PC_IDX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*N-1:0]  rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*N-1:0]  wr_data,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              pc_write,
  input  logic [N-1:0]      pc_update,
  output logic [N-1:0]      pc,
  input  logic              cspr_write,
  input  logic [N-1:0]      cspr_update,
  output logic [N-1:0]      cspr,
  output logic              wr_conflict
);

  logic [N-1:0]     r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [N-1:0]     r_cspr;
  logic [NRD*N-1:0] r_rd_data;
  logic [NRD-1:0]   r_rd_busy;
  logic             r_wr_conflict;

  logic [N-1:0]     w_next_regs [DEPTH];
  logic [DEPTH-1:0] w_hit;
  logic [DEPTH-1:0] w_next_busy;
  logic             w_conflict;
  logic [NRD*N-1:0] w_rd_data;
  logic [NRD-1:0]   w_rd_busy;

  // Resolve the value each register will hold after this edge and its busy bit.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    for (int k = 0; k < DEPTH; k++) begin
      w_next_regs[k] = r_regs[k];
      w_hit[k]       = 1'b0;
      // Later (higher-index) ports overwrite earlier ones, so the highest wins.
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(k))) begin
          w_next_regs[k] = wr_data[p*N +: N];
          w_hit[k]       = 1'b1;
        end
      end
      if (pc_write && (k == PC_IDX)) begin
        w_next_regs[k] = pc_update;
        w_hit[k]       = 1'b1;
      end
      // A fresh reservation beats a same-cycle write: a new producer was issued.
      if (rsv_en && (rsv_addr == AW'(k))) begin
        w_next_busy[k] = 1'b1;
      end else if (w_hit[k]) begin
        w_next_busy[k] = 1'b0;
      end else begin
        w_next_busy[k] = r_busy[k];
      end
    end
  end

  // Flag two or more enabled general ports aiming at one address.
  always_comb begin
    w_conflict = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      for (int q = p + 1; q < NWR; q++) begin
        if (wr_en[p] && wr_en[q] && (wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW])) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  // Write-first read mux: read ports see post-resolution contents.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      w_rd_data[i*N +: N] = w_next_regs[rd_addr[i*AW +: AW]];
      w_rd_busy[i]        = w_next_busy[rd_addr[i*AW +: AW]];
    end
  end

  // State update: array, scoreboard, CPSR and registered read outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register array is reset explicitly because software relies
      // on every register (and therefore pc) reading zero after reset.
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= '0;
      end
      r_busy        <= '0;
      r_cspr        <= '0;
      r_rd_data     <= '0;
      r_rd_busy     <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= w_next_regs[k];
      end
      r_busy        <= w_next_busy;
      if (cspr_write) begin
        r_cspr <= cspr_update;
      end
      r_rd_data     <= w_rd_data;
      r_rd_busy     <= w_rd_busy;
      r_wr_conflict <= w_conflict;
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_busy     = r_rd_busy;
  assign pc          = r_regs[PC_IDX];
  assign cspr        = r_cspr;
  assign wr_conflict = r_wr_conflict;

endmodule
